alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 18 +
 rtl/alu_sequencer_settle_timer.sv | 28 ++
 rtl/alu_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: FSM encoding, function count and
// settle-counter width.
package alu_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int NUM_FUNCS = 8;
    localparam int FUNC_W    = 3;
    localparam int CNT_W     = 4;

    localparam logic [FUNC_W-1:0] LAST_FUNC = FUNC_W'(NUM_FUNCS - 1);

endpackage

// File: rtl/alu_sequencer_settle_timer.sv
// Loadable down-counter that tells the sequencer when the ALU operands have
// been held stable for the programmed number of cycles.
module settle_timer
    import alu_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Sequencer that drives a shared ALU with latched operands, waits for it to
// settle, and captures its result for one function or a scan of all eight.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Mode,
    input  logic [FUNC_W-1:0] Func,
    input  logic [7:0]        SW,
    input  logic [7:0]        ALUOut,
    output logic [FUNC_W-1:0] AluFunc,
    output logic [7:0]        AluSW,
    output logic              Busy,
    output logic              Done,
    output logic [7:0]        Result,
    output logic [FUNC_W-1:0] ResultFunc,
    output logic [7:0]        Hits
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t              state_reg, state_next;
    logic                mode_reg;
    logic [FUNC_W-1:0]   func_reg;
    logic [7:0]          sw_reg;
    logic [7:0]          result_reg;
    logic [FUNC_W-1:0]   rfunc_reg;
    logic [NUM_FUNCS-1:0] hits_reg;

    logic start_run;
    logic in_settle;
    logic in_capture;
    logic last_step;
    logic step_func;
    logic timer_load;
    logic timer_zero;

    assign start_run  = (state_reg == ST_IDLE) && Start;
    assign in_settle  = (state_reg == ST_SETTLE);
    assign in_capture = (state_reg == ST_CAPTURE);
    assign last_step  = !mode_reg || (func_reg == LAST_FUNC);
    assign step_func  = in_capture && !last_step;
    assign timer_load = start_run || step_func;

    settle_timer u_settle_timer (
        .clk   (Clock),
        .srst  (Reset),
        .load  (timer_load),
        .dec   (in_settle),
        .value (SETTLE_LOAD),
        .zero  (timer_zero)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:    if (Start) state_next = ST_SETTLE;
            ST_SETTLE:  if (timer_zero) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = last_step ? ST_DONE : ST_SETTLE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Operands and function select only move at a latch or a scan step, so the
    // ALU sees stable inputs for the whole settle/capture window.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            mode_reg <= 1'b0;
            func_reg <= '0;
            sw_reg   <= '0;
        end else if (start_run) begin
            mode_reg <= Mode;
            func_reg <= Mode ? '0 : Func;
            sw_reg   <= SW;
        end else if (step_func) begin
            func_reg <= func_reg + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            result_reg <= '0;
            rfunc_reg  <= '0;
        end else if (in_capture) begin
            result_reg <= ALUOut;
            rfunc_reg  <= func_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FUNCS; gi++) begin : g_hits
            always_ff @(posedge Clock) begin
                if (Reset) begin
                    hits_reg[gi] <= 1'b0;
                end else if (start_run && Mode) begin
                    hits_reg[gi] <= 1'b0;
                end else if (in_capture && mode_reg &&
                             (func_reg == FUNC_W'(gi)) && (ALUOut != 8'h00)) begin
                    hits_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    assign AluFunc    = func_reg;
    assign AluSW      = sw_reg;
    assign Busy       = (state_reg != ST_IDLE);
    assign Done       = (state_reg == ST_DONE);
    assign Result     = result_reg;
    assign ResultFunc = rfunc_reg;
    assign Hits       = hits_reg;

endmodule
